// File: rtl/lsu_dmem_if.sv
// ----------------------------------------------------------------------------
// lsu_dmem_if : RV32I load/store unit between execute and data memory.
//
// Captures one load/store from execute, runs a req/gnt/rvalid handshake with
// data memory, formats load data (byte/halfword select, sign/zero extend)
// for the writeback mux, and stalls the pipeline while the access is in flight.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   req_valid         load/store present in execute (held while stall=1)
//   mem_wr            1 = store, 0 = load
//   funct3            RV32I width/sign code
//   addr, wdata       byte address (ALU result) and store data (rs2)
//   stall             combinational pipeline freeze
//   data_out          formatted load data, held until the next load completes
//   misaligned        one-cycle alignment fault pulse
//   lsu_err           one-cycle illegal-funct3 pulse
//   dmem_req/we/addr/be/wdata   memory request channel
//   dmem_gnt          request accepted
//   dmem_rvalid/rdata read response
// ----------------------------------------------------------------------------
module lsu_dmem_if (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        mem_wr,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] data_out,
   output logic        misaligned,
   output logic        lsu_err,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned BE_W = XLEN / 8;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_REQ  = 2'b01;
   localparam logic [1:0] S_WAIT = 2'b10;
   localparam logic [1:0] S_DONE = 2'b11;

   // funct3[1:0] encodes the access size
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   logic [1:0]      state_q, state_d;
   logic            req_q, req_d;
   logic            we_q, we_d;
   logic [XLEN-1:0] waddr_q, waddr_d;
   logic [BE_W-1:0] be_q, be_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [2:0]      f3_q, f3_d;
   logic [1:0]      alo_q, alo_d;
   logic            mis_q, mis_d;
   logic            err_q, err_d;
   logic [XLEN-1:0] dout_q, dout_d;

   logic            legal_c;
   logic            misal_c;
   logic [BE_W-1:0] be_c;
   logic [XLEN-1:0] wdata_rep_c;
   logic [7:0]      ld_byte_c;
   logic [15:0]     ld_half_c;
   logic [XLEN-1:0] ld_fmt_c;

   // Request decode: legality, alignment, byte enables, lane replication
   always_comb begin
      legal_c     = 1'b0;
      misal_c     = 1'b0;
      be_c        = {BE_W{1'b1}};
      wdata_rep_c = wdata;

      if (mem_wr) begin
         legal_c = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
      end else begin
         legal_c = (funct3[1:0] != 2'b11) && !(funct3[2] && (funct3[1:0] == SZ_W));
      end

      case (funct3[1:0])
         SZ_H:    misal_c = addr[0];
         SZ_W:    misal_c = (addr[1:0] != 2'b00);
         default: misal_c = 1'b0;
      endcase

      case (funct3[1:0])
         SZ_B: begin
            be_c        = 4'b0001 << addr[1:0];
            wdata_rep_c = {4{wdata[7:0]}};
         end
         SZ_H: begin
            be_c        = addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep_c = {2{wdata[15:0]}};
         end
         default: begin
            be_c        = 4'b1111;
            wdata_rep_c = wdata;
         end
      endcase
   end

   // Load formatting from the captured funct3 / low address bits
   always_comb begin
      case (alo_q)
         2'd0:    ld_byte_c = dmem_rdata[7:0];
         2'd1:    ld_byte_c = dmem_rdata[15:8];
         2'd2:    ld_byte_c = dmem_rdata[23:16];
         default: ld_byte_c = dmem_rdata[31:24];
      endcase
      ld_half_c = alo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

      case (f3_q)
         3'b000:  ld_fmt_c = {{24{ld_byte_c[7]}}, ld_byte_c};
         3'b001:  ld_fmt_c = {{16{ld_half_c[15]}}, ld_half_c};
         3'b100:  ld_fmt_c = {24'd0, ld_byte_c};
         3'b101:  ld_fmt_c = {16'd0, ld_half_c};
         default: ld_fmt_c = dmem_rdata;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      req_d   = 1'b0;
      we_d    = we_q;
      waddr_d = waddr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      f3_d    = f3_q;
      alo_d   = alo_q;
      mis_d   = 1'b0;
      err_d   = 1'b0;
      dout_d  = dout_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = mem_wr;
               waddr_d = {addr[31:2], 2'b00};
               be_d    = be_c;
               wdata_d = wdata_rep_c;
               f3_d    = funct3;
               alo_d   = addr[1:0];
               if (!legal_c) begin
                  // illegal funct3 wins over misalignment
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else if (misal_c) begin
                  mis_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  req_d   = 1'b1;
                  state_d = S_REQ;
               end
            end
         end

         S_REQ: begin
            req_d = 1'b1;
            if (dmem_gnt) begin
               req_d = 1'b0;
               if (we_q) begin
                  state_d = S_DONE;
               end else if (dmem_rvalid) begin
                  // zero-wait memory: response arrives with the grant
                  dout_d  = ld_fmt_c;
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end

         S_WAIT: begin
            if (dmem_rvalid) begin
               dout_d  = ld_fmt_c;
               state_d = S_DONE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
         alo_q   <= '0;
         mis_q   <= 1'b0;
         err_q   <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         f3_q    <= f3_d;
         alo_q   <= alo_d;
         mis_q   <= mis_d;
         err_q   <= err_d;
         dout_q  <= dout_d;
      end
   end

   // Release the pipeline only in the completion cycle; never stall in reset
   assign stall      = rst_n & req_valid & (state_q != S_DONE);

   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = waddr_q;
   assign dmem_be    = be_q;
   assign dmem_wdata = wdata_q;
   assign misaligned = mis_q;
   assign lsu_err    = err_q;
   assign data_out   = dout_q;

endmodule
